// File: rtl/pulse_period_monitor.sv
// Period/lock checker for a periodic single-cycle strobe.
// Define PULSE_MON_SYNC_EN to add a 2-flop input synchronizer.
module pulse_period_monitor #(
  parameter int EXP_PERIOD = 11,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [7:0]       err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [GW-1:0] LCK    = GW'(LOCK_COUNT);
  localparam logic [GW-1:0] LCK_M1 = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCKED
  } state_t;

  state_t r_state, w_state_n;

  logic             w_pin;
  logic             w_edge;
  logic             r_pulse_d;
  logic [CNT_W-1:0] r_ivl, w_ivl_n;
  logic [CNT_W-1:0] r_period, w_period_n;
  logic             r_pv, w_pv_n;
  logic             r_locked, w_locked_n;
  logic             r_early, w_early_n;
  logic             r_late, w_late_n;
  logic [7:0]       r_errc, w_errc_n;
  logic [GW-1:0]    r_good, w_good_n;
  logic             r_missed, w_missed_n;

`ifdef PULSE_MON_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else if (clear) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pin = r_sync2;
`else
  assign w_pin = pulse_in;
`endif

  assign w_edge = w_pin & ~r_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_ivl_n    = r_ivl;
    w_period_n = r_period;
    w_pv_n     = 1'b0;
    w_early_n  = 1'b0;
    w_late_n   = 1'b0;
    w_good_n   = r_good;
    w_locked_n = r_locked;
    w_missed_n = r_missed;
    w_errc_n   = r_errc;
    unique case (r_state)
      S_IDLE: begin
        w_ivl_n = '0;
        if (w_edge) begin
          w_ivl_n   = ONE;
          w_state_n = S_TRACK;
        end
      end
      S_TRACK, S_LOCKED: begin
        w_ivl_n = (r_ivl == SAT) ? SAT : r_ivl + ONE;
        if (w_edge) begin
          w_ivl_n    = ONE;
          w_period_n = r_ivl;
          w_pv_n     = 1'b1;
          w_missed_n = 1'b0;
          if (r_ivl < LO) begin
            w_early_n  = 1'b1;
            w_good_n   = '0;
            w_locked_n = 1'b0;
            w_state_n  = S_TRACK;
          end else if (r_ivl > HI) begin
            // late edge already flagged by the timeout
            w_good_n  = '0;
            w_state_n = S_TRACK;
          end else if (r_good >= LCK_M1) begin
            w_good_n   = LCK;
            w_locked_n = 1'b1;
            w_state_n  = S_LOCKED;
          end else begin
            w_good_n = r_good + GW'(1);
          end
        end else if (r_ivl == HI && !r_missed) begin
          w_late_n   = 1'b1;
          w_missed_n = 1'b1;
          w_good_n   = '0;
          w_locked_n = 1'b0;
          w_state_n  = S_TRACK;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if ((w_early_n || w_late_n) && r_errc != 8'hFF)
      w_errc_n = r_errc + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse_d <= 1'b0;
      r_ivl     <= '0;
      r_period  <= '0;
      r_pv      <= 1'b0;
      r_locked  <= 1'b0;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
      r_errc    <= '0;
      r_good    <= '0;
      r_missed  <= 1'b0;
    end else if (clear) begin
      r_pulse_d <= 1'b0;
      r_ivl     <= '0;
      r_period  <= '0;
      r_pv      <= 1'b0;
      r_locked  <= 1'b0;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
      r_errc    <= '0;
      r_good    <= '0;
      r_missed  <= 1'b0;
    end else begin
      r_pulse_d <= w_pin;
      r_ivl     <= w_ivl_n;
      r_period  <= w_period_n;
      r_pv      <= w_pv_n;
      r_locked  <= w_locked_n;
      r_early   <= w_early_n;
      r_late    <= w_late_n;
      r_errc    <= w_errc_n;
      r_good    <= w_good_n;
      r_missed  <= w_missed_n;
    end
  end

  assign period       = r_period;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign err_early    = r_early;
  assign err_late     = r_late;
  assign err_count    = r_errc;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: two instances (TOL=0, TOL=1)
// against an edge-time model. Honours PULSE_MON_SYNC_EN.
module tb_pulse_period_monitor;

`ifdef PULSE_MON_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit SYNC = 1'b0;
  localparam int LAT  = 1;
`endif
  localparam int LOCKN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse_in = 1'b0;
  logic clear = 1'b0;

  logic [7:0] per0, per1, ec0, ec1;
  logic pv0, lk0, ea0, la0;
  logic pv1, lk1, ea1, la1;

  pulse_period_monitor u0 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
    .period(per0), .period_valid(pv0), .locked(lk0),
    .err_early(ea0), .err_late(la0), .err_count(ec0)
  );

  pulse_period_monitor #(.TOL(1)) u1 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clear(clear),
    .period(per1), .period_valid(pv1), .locked(lk1),
    .err_early(ea1), .err_late(la1), .err_count(ec1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [19:0] obs0, obs1;
  assign obs0 = {per0, pv0, lk0, ea0, la0, ec0};
  assign obs1 = {per1, pv1, lk1, ea1, la1, ec1};

  // Model state: absolute edge times instead of a running counter
  int m_lo[2] = '{11, 10};
  int m_hi[2] = '{11, 12};
  int m_last[2], m_run[2], m_per[2], m_errc[2];
  bit m_armed[2], m_lk[2], m_gapf[2], m_prev[2];
  bit m_pv[2], m_ea[2], m_la[2], m_q0[2], m_q1[2];

  task automatic model_reset(input int k);
    m_last[k] = 0; m_run[k] = 0; m_per[k] = 0; m_errc[k] = 0;
    m_armed[k] = 0; m_lk[k] = 0; m_gapf[k] = 0; m_prev[k] = 0;
    m_pv[k] = 0; m_ea[k] = 0; m_la[k] = 0; m_q0[k] = 0; m_q1[k] = 0;
  endtask

  task automatic model_step(input int k, input bit p, input bit c);
    bit s, e;
    int d;
    if (c) begin
      model_reset(k);
      return;
    end
    s = SYNC ? m_q1[k] : p;
    m_q1[k] = m_q0[k];
    m_q0[k] = p;
    e = s && !m_prev[k];
    m_prev[k] = s;
    m_pv[k] = 0; m_ea[k] = 0; m_la[k] = 0;
    if (e) begin
      if (m_armed[k]) begin
        d = cyc - m_last[k];
        m_per[k] = (d > 255) ? 255 : d;
        m_pv[k] = 1;
        if (d < m_lo[k]) begin
          m_ea[k] = 1; m_run[k] = 0; m_lk[k] = 0;
        end else if (d > m_hi[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] >= LOCKN) m_lk[k] = 1;
        end
      end
      m_armed[k] = 1;
      m_last[k] = cyc;
      m_gapf[k] = 0;
    end else if (m_armed[k] && !m_gapf[k] && cyc - m_last[k] == m_hi[k]) begin
      m_la[k] = 1; m_gapf[k] = 1; m_run[k] = 0; m_lk[k] = 0;
    end
    if ((m_ea[k] || m_la[k]) && m_errc[k] < 255) m_errc[k]++;
  endtask

  function automatic logic [19:0] expv(input int k);
    return {8'(m_per[k]), m_pv[k], m_lk[k], m_ea[k], m_la[k], 8'(m_errc[k])};
  endfunction

  task automatic tick(input bit p, input bit c);
    @(negedge clk);
    pulse_in = p;
    clear = c;
    @(posedge clk);
    cyc++;
    model_step(0, p, c);
    model_step(1, p, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset(0);
    model_reset(1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== 20'h0) begin
      errors++; $display("FAIL reset0 got=%h exp=0", obs0);
    end
    checks++;
    if (obs1 !== 20'h0) begin
      errors++; $display("FAIL reset1 got=%h exp=0", obs1);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_steady();
    int ivs[$] = '{11, 11, 11, 11, 11, 4};
    int npv = 0, nerr = 0, lock_at = 0;
    logic [7:0] lastp = '0;
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL steady cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (pv0) begin
        npv++; lastp = per0;
        if (lk0 && lock_at == 0) lock_at = npv;
      end
      if (ea0 || la0) nerr++;
    end
    checks++;
    if (npv != 5) begin errors++; $display("FAIL steady_npv got=%0d exp=5", npv); end
    checks++;
    if (lock_at != 4) begin errors++; $display("FAIL steady_lock got=%0d exp=4", lock_at); end
    checks++;
    if (lastp !== 8'd11) begin errors++; $display("FAIL steady_period got=%0d exp=11", lastp); end
    checks++;
    if (nerr != 0 || ec0 !== 8'd0) begin
      errors++; $display("FAIL steady_err got=%0d/%0d exp=0", nerr, ec0);
    end
  endtask

  task automatic test_early();
    int ivs[$] = '{11, 11, 11, 11, 11, 8, 11, 11, 11, 11, 4};
    int nea = 0;
    bit seen = 0;
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL early cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (ea0) begin
        nea++;
        seen = (per0 == 8'd8) && pv0 && !lk0 && (ec0 == 8'd1);
      end
    end
    checks++;
    if (nea != 1 || !seen) begin
      errors++; $display("FAIL early_strobe got=%0d/%0d exp=1/1", nea, seen);
    end
    checks++;
    if (lk0 !== 1'b1 || ec0 !== 8'd1) begin
      errors++; $display("FAIL early_relock got=%0d/%0d exp=1/1", lk0, ec0);
    end
  endtask

  task automatic test_late();
    int ivs[$] = '{11, 11, 11, 11, 11, 30, 4};
    int nla = 0;
    bit drop = 0;
    logic [7:0] lastp = '0;
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL late cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (la0) begin nla++; drop = !lk0; end
      if (pv0) lastp = per0;
    end
    checks++;
    if (nla != 1 || !drop) begin
      errors++; $display("FAIL late_strobe got=%0d/%0d exp=1/1", nla, drop);
    end
    checks++;
    if (lastp !== 8'd30 || ec0 !== 8'd1) begin
      errors++; $display("FAIL late_period got=%0d/%0d exp=30/1", lastp, ec0);
    end
  endtask

  task automatic test_saturate();
    int ivs[$];
    int nla = 0;
    logic [7:0] lastp = '0;
    ivs = '{11, 0, 4};
    ivs[1] = $urandom_range(300, 260);
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL sat cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (la0) nla++;
      if (pv0) lastp = per0;
    end
    checks++;
    if (lastp !== 8'd255 || nla != 1) begin
      errors++; $display("FAIL sat_period got=%0d/%0d exp=255/1", lastp, nla);
    end
  endtask

  task automatic test_tol();
    int ivs[$] = '{10, 12, 11, 10, 13, 4};
    int npv = 0, lock_at = 0, nla = 0, nea = 0;
    bit drop = 0;
    logic [7:0] lastp = '0;
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs1 !== expv(1)) begin
        errors++; $display("FAIL tol cyc=%0d got=%h exp=%h", cyc, obs1, expv(1));
      end
      if (pv1) begin
        npv++; lastp = per1;
        if (lk1 && lock_at == 0) lock_at = npv;
      end
      if (la1) begin nla++; drop = !lk1; end
      if (ea1) nea++;
    end
    checks++;
    if (lock_at != 4 || nea != 0) begin
      errors++; $display("FAIL tol_lock got=%0d/%0d exp=4/0", lock_at, nea);
    end
    checks++;
    if (nla != 1 || !drop || lastp !== 8'd13) begin
      errors++; $display("FAIL tol_late got=%0d/%0d/%0d exp=1/1/13", nla, drop, lastp);
    end
  endtask

  task automatic test_wide();
    int ivs[$] = '{11, 11, 11, 11, 11, 6};
    int hl, npv = 0, nerr = 0, npost = 0;
    bit allp = 1;
    hl = $urandom_range(5, 2);
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) begin
      tick(j < hl, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL wide cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (pv0) begin npv++; if (per0 !== 8'd11) allp = 0; end
      if (ea0 || la0) nerr++;
    end
    checks++;
    if (npv != 5 || !allp || nerr != 0) begin
      errors++; $display("FAIL wide_count got=%0d/%0d/%0d exp=5/1/0", npv, allp, nerr);
    end
    tick(0, 1);
    checks++;
    if (obs0 !== 20'h0) begin
      errors++; $display("FAIL wide_clear got=%h exp=0", obs0);
    end
    for (int j = 0; j < 11; j++) begin
      tick(j < hl, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL wide_post cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (pv0) npost++;
    end
    checks++;
    if (npost != 0) begin errors++; $display("FAIL wide_first got=%0d exp=0", npost); end
  endtask

  task automatic test_async_rst();
    int ivs[$] = '{11, 11, 11, 11, 11, 5};
    int iv2[$] = '{11, 11, 4};
    int npv = 0;
    tick(0, 1);
    foreach (ivs[k]) for (int j = 0; j < ivs[k]; j++) tick(j == 0, 0);
    checks++;
    if (lk0 !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0d exp=1", lk0); end
    #2 rst = 1'b1;
    pulse_in = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checks++;
    if (obs0 !== 20'h0) begin errors++; $display("FAIL arst0 got=%h exp=0", obs0); end
    checks++;
    if (obs1 !== 20'h0) begin errors++; $display("FAIL arst1 got=%h exp=0", obs1); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    foreach (iv2[k]) for (int j = 0; j < iv2[k]; j++) begin
      tick(j == 0, 0);
      checks++;
      if (obs0 !== expv(0)) begin
        errors++; $display("FAIL arst_post cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
      end
      if (pv0) npv++;
    end
    checks++;
    if (npv != 2) begin errors++; $display("FAIL arst_npv got=%0d exp=2", npv); end
  endtask

  task automatic test_latency();
    int n;
    bit got;
    tick(0, 1);
    tick(1, 0);
    for (int j = 0; j < 10; j++) tick(0, 0);
    tick(1, 0);
    n = 1;
    got = pv0;
    while (!got && n < 8) begin
      tick(0, 0);
      n++;
      got = pv0;
    end
    checks++;
    if (!got || n != LAT) begin
      errors++; $display("FAIL latency got=%0d/%0d exp=1/%0d", got, n, LAT);
    end
  endtask

  task automatic test_random();
    int iv, hl;
    tick(0, 1);
    for (int k = 0; k < 40; k++) begin
      iv = ($urandom_range(9, 0) == 0) ? $urandom_range(40, 15) : $urandom_range(13, 8);
      hl = $urandom_range(3, 1);
      for (int j = 0; j < iv; j++) begin
        tick(j < hl, 0);
        checks++;
        if (obs0 !== expv(0)) begin
          errors++; $display("FAIL random0 cyc=%0d got=%h exp=%h", cyc, obs0, expv(0));
        end
        checks++;
        if (obs1 !== expv(1)) begin
          errors++; $display("FAIL random1 cyc=%0d got=%h exp=%h", cyc, obs1, expv(1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_early();
    test_late();
    test_saturate();
    test_tol();
    test_wide();
    test_async_rst();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
Receive-side checker for the periodic single-cycle strobe produced by the team's pulse generator. It measures the clock-cycle interval between successive rising edges on pulse_in and compares it with an expected period and tolerance. It then reports lock status, early and late (missing) pulse errors, and a saturating error count. It sits at the consumer end of the strobe, feeding status and debug registers.

Parameters:
EXP_PERIOD, 11, expected cycles between consecutive rising edges (matches generator period 0..10 count)
TOL, 0, allowed +/- deviation in cycles; require TOL < EXP_PERIOD
LOCK_COUNT, 4, consecutive in-tolerance intervals needed to assert locked (>=1)
CNT_W, 8, interval counter/period width; must satisfy 2^CNT_W-1 >= EXP_PERIOD+TOL+1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
pulse_in  in  1  strobe under test; sampled synchronously, edge-detected
clear  in  1  synchronous soft clear, same effect as reset but clocked
period  out  CNT_W  last measured interval in cycles
period_valid  out  1  one-cycle strobe: period updated
locked  out  1  high while LOCK_COUNT+ consecutive good intervals seen and no error since
err_early  out  1  one-cycle strobe: interval < EXP_PERIOD-TOL
err_late  out  1  one-cycle strobe: no edge by EXP_PERIOD+TOL cycles
err_count  out  8  saturating count of err_early+err_late events (sticks at 255)

Behaviour:
- Reset (rst async, or clear sync): state IDLE; period=0, period_valid=0, locked=0, err_early=0, err_late=0, err_count=0; ivl=0, good_cnt=0, pulse_d=0, missed=0. clear has priority over all other events in its cycle.
- Edge detect: edge = pulse_in & ~pulse_d; pulse_d registers pulse_in. A level held high counts once.
- ivl counter: on edge, ivl<=1; otherwise ivl<=ivl+1, saturating at 2^CNT_W-1.
- States: IDLE, TRACK, LOCKED.
- IDLE: ivl is held at 0. First edge -> ivl<=1, go TRACK. No period_valid and no error on the first edge.
- TRACK/LOCKED, edge seen:
  - period<=ivl (the pre-update value) and period_valid=1 in the next cycle. Latency is 1 clock from the sampled edge.
  - If EXP_PERIOD-TOL <= ivl <= EXP_PERIOD+TOL (good): good_cnt<=good_cnt+1, saturating at LOCK_COUNT. When it reaches LOCK_COUNT, go LOCKED and locked=1 (same cycle as period_valid).
  - If ivl < EXP_PERIOD-TOL: err_early=1, good_cnt<=0, locked<=0, go TRACK.
  - If ivl > EXP_PERIOD+TOL: late edge after timeout. No second err_late; good_cnt<=0, stay TRACK; period still reported.
  - missed<=0 on every edge.
- Timeout: in TRACK/LOCKED, no edge while ivl==EXP_PERIOD+TOL and missed==0 -> next cycle err_late=1, missed<=1, good_cnt<=0, locked<=0, go TRACK. Fires exactly once per gap, however long the gap is.
- Edge arriving in the cycle ivl==EXP_PERIOD+TOL counts as good; no timeout.
- err_count increments by 1 on each err_early or err_late strobe (never both in one cycle), saturating at 255.
- Saturated ivl reports period=2^CNT_W-1.
- Strobes (period_valid, err_early, err_late) are high for exactly one cycle.
- All outputs are registered.
- rst asserted mid-interval clears immediately and asynchronously. The first edge after release is treated as the IDLE first edge.

Optional Feature:
Macro PULSE_MON_SYNC_EN.
- Defined: pulse_in passes through a 2-flop synchronizer (reset to 0) before edge detect. This adds 2 cycles of input-to-output latency; measured periods are unchanged.
- Undefined: pulse_in is assumed synchronous to clk and is used directly.

Test Plan:
- Defaults, strobe every 11 cycles for 6 pulses -> 5 period_valid strobes with period=11, locked rises with the 4th valid, errors 0, err_count=0.
- Locked, then one pulse 8 cycles after previous -> period=8, err_early strobe, locked=0, err_count=1; 4 further 11-cycle intervals relock.
- Locked, then pulses stop -> exactly one err_late 12 cycles after last edge, locked=0; next edge 30 cycles later -> period=30, no extra err_late, err_count=1.
- TOL=1: intervals 10, 12, 11, 10 -> all good, locked after 4th; interval 13 -> err_late at ivl==12 (timeout), locked=0.
- pulse_in held high 5 cycles each period of 11 -> single edge per period, period=11; clear mid-stream -> all outputs 0, next edge gives no period_valid.
- rst asserted asynchronously mid-interval with locked=1 -> all outputs 0 without a clock edge; with PULSE_MON_SYNC_EN defined, period_valid lags the edge by 3 cycles instead of 1.
